// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: issue/response sequencer in front of the alu datapath.
// Accepts one operation at a time (valid/ready), drives the ALU operands and
// opcode, and holds them across a multi-cycle multiply window. It owns the
// architectural HI/LO registers, answers C_MFHI/C_MFLO from them, and
// returns result/branch/flags on a valid/ready response channel.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready/req_*        issue request channel
//   alu_reg_a/b, alu_opsel,
//   alu_ir_shift                     registered drive into the alu
//   alu_result(_hi), alu_branch_taken,
//   alu_carry, alu_borrow            alu outputs sampled at end of EXEC
//   rsp_valid/rsp_ready/rsp_*        response channel
//   hi_q, lo_q                       architectural HI/LO
//   perf_op_count, perf_stall_count  performance counters
//
// Build option: define ALU_PERF_CNT_EN to implement the performance
// counters; when undefined both perf ports read 0 and no counter flops exist.

package alu_pkg;
    typedef enum logic [4:0] {
        C_NOP   = 5'd0,
        C_ADD_U = 5'd1,
        C_ADD   = 5'd2,
        C_SUB_U = 5'd3,
        C_SUB   = 5'd4,
        C_AND   = 5'd5,
        C_OR    = 5'd6,
        C_XOR   = 5'd7,
        C_NOR   = 5'd8,
        C_SLL   = 5'd9,
        C_SRL   = 5'd10,
        C_SRA   = 5'd11,
        C_SLT   = 5'd12,
        C_SLTU  = 5'd13,
        C_BEQ   = 5'd14,
        C_BNE   = 5'd15,
        C_MULT  = 5'd16,
        C_MUL_U = 5'd17,
        C_MFHI  = 5'd18,
        C_MFLO  = 5'd19
    } alu_sel_t;
endpackage

module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 4     // legal range 1..16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  alu_sel_t         req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [4:0]       req_shift,
    output logic [WIDTH-1:0] alu_reg_a,
    output logic [WIDTH-1:0] alu_reg_b,
    output alu_sel_t         alu_opsel,
    output logic [4:0]       alu_ir_shift,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] alu_result_hi,
    input  logic             alu_branch_taken,
    input  logic             alu_carry,
    input  logic             alu_borrow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_branch_taken,
    output logic             rsp_carry,
    output logic             rsp_borrow,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q,
    output logic [31:0]      perf_op_count,
    output logic [31:0]      perf_stall_count
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] reg_a_q,  reg_a_d;
    logic [WIDTH-1:0] reg_b_q,  reg_b_d;
    alu_sel_t         opsel_q,  opsel_d;
    logic [4:0]       shift_q,  shift_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] hi_d,     lo_d;
    logic             vld_q,    vld_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             br_q,     br_d;
    logic             cy_q,     cy_d;
    logic             bo_q,     bo_d;
    logic             accept_c;
    logic             is_mult_c;

    // No skid buffer: ready only while idle and out of reset.
    assign req_ready = (state_q == S_IDLE) && !rst;
    assign accept_c  = req_valid && req_ready;
    assign is_mult_c = (opsel_q == C_MULT) || (opsel_q == C_MUL_U);

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        opsel_d = opsel_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        vld_d   = vld_q;
        res_d   = res_q;
        br_d    = br_q;
        cy_d    = cy_q;
        bo_d    = bo_q;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    reg_a_d = req_a;
                    reg_b_d = req_b;
                    opsel_d = req_op;
                    shift_d = req_shift;
                    if ((req_op == C_MFHI) || (req_op == C_MFLO)) begin
                        // HI/LO moves bypass the ALU entirely.
                        res_d   = (req_op == C_MFHI) ? hi_q : lo_q;
                        br_d    = 1'b0;
                        cy_d    = 1'b0;
                        bo_d    = 1'b0;
                        vld_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        if ((req_op == C_MULT) || (req_op == C_MUL_U)) begin
                            cnt_d = CNT_W'(MULT_CYCLES - 1);
                        end else begin
                            cnt_d = '0;
                        end
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    res_d = alu_result;
                    br_d  = alu_branch_taken;
                    cy_d  = alu_carry;
                    bo_d  = alu_borrow;
                    if (is_mult_c) begin
                        hi_d = alu_result_hi;
                        lo_d = alu_result;
                    end
                    vld_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    vld_d   = 1'b0;
                    opsel_d = C_NOP;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            reg_a_q <= '0;
            reg_b_q <= '0;
            opsel_q <= C_NOP;
            shift_q <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            vld_q   <= 1'b0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cy_q    <= 1'b0;
            bo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            opsel_q <= opsel_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            vld_q   <= vld_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cy_q    <= cy_d;
            bo_q    <= bo_d;
        end
    end

    assign alu_reg_a        = reg_a_q;
    assign alu_reg_b        = reg_b_q;
    assign alu_opsel        = opsel_q;
    assign alu_ir_shift     = shift_q;
    assign rsp_valid        = vld_q;
    assign rsp_result       = res_q;
    assign rsp_branch_taken = br_q;
    assign rsp_carry        = cy_q;
    assign rsp_borrow       = bo_q;

`ifdef ALU_PERF_CNT_EN
    logic [31:0] op_cnt_q,    op_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating counters: accepted requests and multiply wait cycles.
    always_comb begin
        op_cnt_d    = op_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (accept_c && (op_cnt_q != 32'hFFFF_FFFF)) begin
            op_cnt_d = op_cnt_q + 32'd1;
        end
        if ((state_q == S_EXEC) && (cnt_q != '0) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            op_cnt_q    <= op_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_op_count    = op_cnt_q;
    assign perf_stall_count = stall_cnt_q;
`else
    assign perf_op_count    = 32'd0;
    assign perf_stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Testbench for alu_seq_ctrl (WIDTH=8, MULT_CYCLES=4) with a behavioural
// stand-in for the alu. The driver pushes hand-computed expectations into a
// scoreboard queue at accept; a monitor pops and compares on each response
// handshake.

module tb_alu_seq_ctrl;
    import alu_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned MC = 4;

    logic           clk;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    alu_sel_t       req_op;
    logic [W-1:0]   req_a;
    logic [W-1:0]   req_b;
    logic [4:0]     req_shift;
    logic [W-1:0]   alu_reg_a;
    logic [W-1:0]   alu_reg_b;
    alu_sel_t       alu_opsel;
    logic [4:0]     alu_ir_shift;
    logic [W-1:0]   alu_result;
    logic [W-1:0]   alu_result_hi;
    logic           alu_branch_taken;
    logic           alu_carry;
    logic           alu_borrow;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_result;
    logic           rsp_branch_taken;
    logic           rsp_carry;
    logic           rsp_borrow;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;
    logic [31:0]    perf_op_count;
    logic [31:0]    perf_stall_count;

    int errors = 0;
    int checks = 0;

    alu_seq_ctrl #(.WIDTH(W), .MULT_CYCLES(MC)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_shift        (req_shift),
        .alu_reg_a        (alu_reg_a),
        .alu_reg_b        (alu_reg_b),
        .alu_opsel        (alu_opsel),
        .alu_ir_shift     (alu_ir_shift),
        .alu_result       (alu_result),
        .alu_result_hi    (alu_result_hi),
        .alu_branch_taken (alu_branch_taken),
        .alu_carry        (alu_carry),
        .alu_borrow       (alu_borrow),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_result       (rsp_result),
        .rsp_branch_taken (rsp_branch_taken),
        .rsp_carry        (rsp_carry),
        .rsp_borrow       (rsp_borrow),
        .hi_q             (hi_q),
        .lo_q             (lo_q),
        .perf_op_count    (perf_op_count),
        .perf_stall_count (perf_stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural alu for the opcodes exercised here.
    logic signed [15:0] sprod;
    logic [15:0]        uprod;
    always_comb begin
        sprod = $signed({{8{alu_reg_a[7]}}, alu_reg_a}) * $signed({{8{alu_reg_b[7]}}, alu_reg_b});
        uprod = {8'd0, alu_reg_a} * {8'd0, alu_reg_b};
        alu_result       = '0;
        alu_result_hi    = '0;
        alu_branch_taken = 1'b0;
        alu_carry        = 1'b0;
        alu_borrow       = 1'b0;
        case (alu_opsel)
            C_ADD_U: {alu_carry, alu_result} = {1'b0, alu_reg_a} + {1'b0, alu_reg_b};
            C_SUB_U: begin
                alu_result = alu_reg_a - alu_reg_b;
                alu_borrow = (alu_reg_a < alu_reg_b);
            end
            C_SLL:   alu_result = alu_reg_b << alu_ir_shift;
            C_BEQ:   alu_branch_taken = (alu_reg_a == alu_reg_b);
            C_MULT:  {alu_result_hi, alu_result} = sprod;
            C_MUL_U: {alu_result_hi, alu_result} = uprod;
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        logic [W-1:0] res;
        logic         br;
        logic         cy;
        logic         bo;
        logic         hl;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        name;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare on every response handshake.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got result 0x%0h with empty scoreboard", rsp_result);
            end else begin
                mon_e = sbq.pop_front();
                chk({mon_e.name, "_result"}, 32'(rsp_result), 32'(mon_e.res));
                chk({mon_e.name, "_branch"}, 32'(rsp_branch_taken), 32'(mon_e.br));
                chk({mon_e.name, "_carry"}, 32'(rsp_carry), 32'(mon_e.cy));
                chk({mon_e.name, "_borrow"}, 32'(rsp_borrow), 32'(mon_e.bo));
                if (mon_e.hl) begin
                    chk({mon_e.name, "_hi"}, 32'(hi_q), 32'(mon_e.hi));
                    chk({mon_e.name, "_lo"}, 32'(lo_q), 32'(mon_e.lo));
                end
            end
        end
    end

    // Issue one op with rsp_ready high, check latency, busy, operand hold
    // and the return of alu_opsel to C_NOP. Entered and left at posedge+#1.
    task automatic run_op(input alu_sel_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] sh, input logic [W-1:0] er, input logic ebr,
                          input logic ecy, input logic ebo, input logic hl,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input int lat, input string nm);
        exp_t x;
        int   k;
        bit   got;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_shift = sh;
        req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
        end
        chk({nm, "_accept"}, 32'(got), 32'd1);
        x.res = er; x.br = ebr; x.cy = ecy; x.bo = ebo;
        x.hl = hl; x.hi = ehi; x.lo = elo; x.name = nm;
        if (got) sbq.push_back(x);
        @(posedge clk);
        #1 req_valid = 1'b0;
        k   = 0;
        got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (rsp_valid) got = 1'b1;
            chk({nm, "_busy"}, 32'(req_ready), 32'd0);
            chk({nm, "_opsel_hold"}, 32'(alu_opsel), 32'(op));
            chk({nm, "_regb_hold"}, 32'(alu_reg_b), 32'(b));
        end
        chk({nm, "_latency"}, 32'(k), 32'(lat));
        @(posedge clk);
        #1;
        chk({nm, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({nm, "_opsel_nop"}, 32'(alu_opsel), 32'(C_NOP));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = C_NOP;
        req_a     = '0;
        req_b     = '0;
        req_shift = '0;
        rsp_ready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_opsel", 32'(alu_opsel), 32'(C_NOP));
        chk("rst_reg_a", 32'(alu_reg_a), 32'd0);
        chk("rst_hi", 32'(hi_q), 32'd0);
        chk("rst_lo", 32'(lo_q), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_perf_ops", perf_op_count, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Multiply then HI/LO moves, then a carrying add.
        run_op(C_MULT, 8'hFD, 8'h05, 5'd0, 8'hF1, 0, 0, 0, 1, 8'hFF, 8'hF1, MC + 1, "mult");
        run_op(C_MFHI, 8'h00, 8'h00, 5'd0, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, 1, "mfhi");
        run_op(C_MFLO, 8'h00, 8'h00, 5'd0, 8'hF1, 0, 0, 0, 0, 8'h00, 8'h00, 1, "mflo");
        run_op(C_ADD_U, 8'd200, 8'd100, 5'd0, 8'd44, 0, 1, 0, 0, 8'h00, 8'h00, 2, "add_carry");

`ifdef ALU_PERF_CNT_EN
        chk("perf_ops", perf_op_count, 32'd4);
        chk("perf_stalls", perf_stall_count, 32'd3);
`else
        chk("perf_ops_off", perf_op_count, 32'd0);
        chk("perf_stalls_off", perf_stall_count, 32'd0);
`endif

        // Unsigned multiply distinguishes from signed; borrow on subtract.
        run_op(C_MUL_U, 8'hFD, 8'h05, 5'd0, 8'hF1, 0, 0, 0, 1, 8'h04, 8'hF1, MC + 1, "mulu");
        run_op(C_MFHI, 8'h00, 8'h00, 5'd0, 8'h04, 0, 0, 0, 0, 8'h00, 8'h00, 1, "mfhi2");
        run_op(C_SUB_U, 8'd5, 8'd9, 5'd0, 8'hFC, 0, 0, 1, 0, 8'h00, 8'h00, 2, "sub_borrow");

        // Response backpressure with a competing request held on the bus.
        begin
            exp_t x;
            rsp_ready = 1'b0;
            req_op = C_BEQ; req_a = 8'd7; req_b = 8'd7; req_shift = 5'd0;
            req_valid = 1'b1;
            @(negedge clk);
            chk("beq_accept", 32'(req_ready), 32'd1);
            x.res = 8'h00; x.br = 1'b1; x.cy = 1'b0; x.bo = 1'b0;
            x.hl = 1'b0; x.hi = 8'h00; x.lo = 8'h00; x.name = "beq";
            sbq.push_back(x);
            @(posedge clk);
            #1;
            req_op = C_ADD_U; req_a = 8'd10; req_b = 8'd20;
            @(negedge clk);
            chk("beq_exec_valid", 32'(rsp_valid), 32'd0);
            chk("beq_exec_busy", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (i == 3) rsp_ready = 1'b1;
                @(negedge clk);
                chk("beq_hold_valid", 32'(rsp_valid), 32'd1);
                chk("beq_hold_branch", 32'(rsp_branch_taken), 32'd1);
                chk("beq_hold_busy", 32'(req_ready), 32'd0);
                @(posedge clk);
                #1;
            end
            chk("beq_released", 32'(rsp_valid), 32'd0);
        end
        run_op(C_ADD_U, 8'd10, 8'd20, 5'd0, 8'd30, 0, 0, 0, 0, 8'h00, 8'h00, 2, "held_add");

        // Shift with operand hold through EXEC.
        run_op(C_SLL, 8'h00, 8'h81, 5'd1, 8'h02, 0, 0, 0, 0, 8'h00, 8'h00, 2, "sll");

        // Reset aborts a multiply in its second EXEC cycle.
        req_op = C_MULT; req_a = 8'd3; req_b = 8'd3; req_shift = 5'd0;
        req_valid = 1'b1;
        @(negedge clk);
        chk("abort_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_idle_ready", 32'(req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_opsel", 32'(alu_opsel), 32'(C_NOP));
        chk("abort_hi", 32'(hi_q), 32'd0);
        chk("abort_lo", 32'(lo_q), 32'd0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid || (hi_q != '0) || (lo_q != '0)) bad++;
        end
        chk("abort_quiet", 32'(bad), 32'd0);

`ifndef ALU_PERF_CNT_EN
        chk("perf_ops_off_end", perf_op_count, 32'd0);
        chk("perf_stalls_off_end", perf_stall_count, 32'd0);
`endif
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
